// File: rtl/chrono_pkg.sv
// Shared state encoding, default timing parameters and widths for the chrono lap controller.
package chrono_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned TICK_PERIOD_DEF     = 500000;
  localparam int unsigned TICK_W              = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_LAP     = 2'd2,
    ST_PAUSED  = 2'd3
  } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and single-cycle press event for one raw button.
module button_debouncer
  import chrono_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             vld1_q, vld1_d;
  logic             vld2_q, vld2_d;
  logic             armed_q, armed_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // A press is only reported once the synchronized level has been seen low
  // after reset, so a button held through reset release stays silent.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    vld1_d   = 1'b1;
    vld2_d   = vld1_q;
    armed_d  = armed_q | (vld2_q & ~sync2_q);
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = sync2_q & armed_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      armed_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      vld1_q   <= vld1_d;
      vld2_q   <= vld2_d;
      armed_q  <= armed_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_evt = press_q;

endmodule

// File: rtl/chrono_lap_controller.sv
// Stopwatch control: debounced buttons drive an IDLE/RUNNING/LAP/PAUSED FSM and a tick generator.
module chrono_lap_controller
  import chrono_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TICK_PERIOD     = TICK_PERIOD_DEF
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic btn_start_stop,
  input  logic btn_lap,
  input  logic btn_clear,
  output logic tick_out,
  output logic counter_clear,
  output logic lap_capture,
  output logic display_freeze,
  output logic running
);

  logic start_evt, lap_evt, clear_evt;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(qzt_clk), .rst_n(reset), .btn_raw(btn_start_stop), .press_evt(start_evt)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(qzt_clk), .rst_n(reset), .btn_raw(btn_lap), .press_evt(lap_evt)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(qzt_clk), .rst_n(reset), .btn_raw(btn_clear), .press_evt(clear_evt)
  );

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;
  logic              clear_q, clear_d;
  logic              lap_q, lap_d;
  logic              freeze_q, freeze_d;
  logic              running_q, running_d;

  // Event priority is clear > start > lap; an event a state ignores does not block lower ones.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    lap_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_evt)      clear_d = 1'b1;
        else if (start_evt) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (start_evt) state_d = ST_PAUSED;
        else if (lap_evt) begin
          state_d = ST_LAP;
          lap_d   = 1'b1;
        end
      end
      ST_LAP: begin
        if (clear_evt)      state_d = ST_RUNNING;
        else if (start_evt) state_d = ST_PAUSED;
        else if (lap_evt)   lap_d   = 1'b1;
      end
      ST_PAUSED: begin
        if (clear_evt) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end else if (start_evt) state_d = ST_RUNNING;
      end
      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d == ST_RUNNING) || (state_d == ST_LAP);
    freeze_d  = (state_d == ST_LAP);
  end

  // Tick phase advances only while counting, holds while paused, and is zeroed in IDLE.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    if ((state_q == ST_RUNNING) || (state_q == ST_LAP)) begin
      if (tick_cnt_q == TICK_W'(TICK_PERIOD - 1)) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
    end
    if (state_d == ST_IDLE) tick_cnt_d = '0;
  end

  always_ff @(posedge qzt_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      clear_q    <= 1'b0;
      lap_q      <= 1'b0;
      freeze_q   <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      clear_q    <= clear_d;
      lap_q      <= lap_d;
      freeze_q   <= freeze_d;
      running_q  <= running_d;
    end
  end

  assign tick_out       = tick_q;
  assign counter_clear  = clear_q;
  assign lap_capture    = lap_q;
  assign display_freeze = freeze_q;
  assign running        = running_q;

endmodule

// File: doc/chrono_lap_controller.md
CHRONO_LAP_CONTROLLER -- requirements
Module: chrono_lap_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, shall set the number of qzt_clk cycles a synchronized button level must be stable before it is accepted (10 ms at 50 MHz).
REQ-002 Parameter TICK_PERIOD, default 500000, shall set the number of qzt_clk cycles per tick_out pulse (100 Hz at 50 MHz); legal range 2..2^30-1.
REQ-003 qzt_clk  input  1  shall be the single system clock; all logic is rising-edge.
REQ-004 reset  input  1  shall be the asynchronous, active-low reset.
REQ-005 btn_start_stop  input  1  shall be the raw, asynchronous, active-high start/stop button.
REQ-006 btn_lap  input  1  shall be the raw, asynchronous, active-high lap button.
REQ-007 btn_clear  input  1  shall be the raw, asynchronous, active-high clear button.
REQ-008 tick_out  output  1  shall be the one-cycle count pulse for the downstream seconds counters.
REQ-009 counter_clear  output  1  shall be a one-cycle pulse that clears the downstream counters.
REQ-010 lap_capture  output  1  shall be a one-cycle pulse that loads the downstream lap latch.
REQ-011 display_freeze  output  1  shall select the latched lap value (1) or the live count (0) at the display mux.
REQ-012 running  output  1  shall be high in RUNNING and LAP states.

Function
REQ-013 Each button shall pass a 2-FF synchronizer, then a debouncer; the debouncer shall emit one single-cycle press event per accepted low-to-high transition and none on release.
REQ-014 A level change shall be accepted only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level; any glitch shall restart the stability count.
REQ-015 The press-event latency from a stable raw edge shall be exactly 2 + DEBOUNCE_CYCLES cycles; state and outputs shall update on the following edge.
REQ-016 The FSM shall have the states IDLE, RUNNING, LAP and PAUSED.
REQ-017 IDLE: on start -> RUNNING; on clear -> assert counter_clear and stay in IDLE; ignore lap.
REQ-018 RUNNING: on start -> PAUSED; on lap -> LAP with a lap_capture pulse; ignore clear.
REQ-019 LAP: on lap -> stay in LAP with a new lap_capture pulse (split); on clear -> RUNNING (release freeze, no counter_clear); on start -> PAUSED.
REQ-020 PAUSED: on start -> RUNNING; on clear -> IDLE, asserting counter_clear and zeroing the tick phase; ignore lap.
REQ-021 Events arriving in the same cycle shall be prioritized clear > start > lap; lower-priority events in that cycle shall be discarded.
REQ-022 display_freeze shall be 1 only in LAP.
REQ-023 The 30-bit tick counter shall advance only in RUNNING or LAP; it shall pulse tick_out and wrap to 0 when it reaches TICK_PERIOD-1.
REQ-024 The tick counter shall hold its phase in PAUSED, so resume continues the partial period; it shall be zeroed in IDLE.
REQ-025 All outputs shall be registered, with no combinational path from any button input.

Reset
REQ-026 While reset is low: state=IDLE, all synchronizer, debouncer and tick counters = 0, and all outputs = 0, asynchronously.
REQ-027 A button held during reset release shall produce no event until it is released and pressed again.
REQ-028 Reset asserted mid-count shall drop tick_out and running within the same cycle; no counter_clear pulse shall be generated by reset.

Structure
REQ-029 State encodings (2-bit) and the default DEBOUNCE_CYCLES and TICK_PERIOD values shall live in the shared package chrono_pkg.
REQ-030 The debouncer shall be the sub-module button_debouncer (synchronizer + stability counter + edge event), instantiated three times.

Verification (DEBOUNCE_CYCLES=4, TICK_PERIOD=5)
REQ-031 Start press held 10 cycles -> one event at +6 cycles, running=1 on the next cycle, and tick_out every 5th cycle thereafter.
REQ-032 A 3-cycle glitch on btn_lap during RUNNING -> no lap_capture and display_freeze stays 0.
REQ-033 RUNNING, lap, lap -> two lap_capture pulses with display_freeze=1 throughout; then clear -> display_freeze=0, state RUNNING, no counter_clear.
REQ-034 Stop after 2 of 5 period cycles, then resume -> first tick_out arrives 3 active cycles after resume.
REQ-035 Start and clear events in the same cycle while PAUSED -> IDLE with a single counter_clear pulse and no transition to RUNNING.
REQ-036 Reset pulsed low in LAP -> all outputs 0 immediately; a button held through reset release -> no event.
